writeback_stage: RTL and testbench



---
 rtl/wb_pkg.sv | 11 +
 rtl/writeback_stage_load_align.sv | 33 +++
 rtl/writeback_stage.sv | 91 +++++++++
 tb/tb_writeback_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback stage.
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_AW_DEF = 5;
  typedef enum logic [1:0] {IDLE, WAIT_MEM, SETUP, STROBE} wb_state_t;
  localparam logic [2:0] F3_LB = 3'b000;
  localparam logic [2:0] F3_LH = 3'b001;
  localparam logic [2:0] F3_LW = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/writeback_stage_load_align.sv
// load_align: extracts, aligns and extends load data; flags illegal or misaligned loads.
module load_align import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);
  logic [7:0] w_byte;
  logic [15:0] w_half;
  assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign w_half = rdata[{addr_lo[1], 4'b0000} +: 16];
  always_comb begin
    data = rdata;
    illegal = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH: begin
        data = {{(XLEN-16){w_half[15]}}, w_half};
        illegal = addr_lo[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, w_half};
        illegal = addr_lo[0];
      end
      F3_LW:  illegal = |addr_lo;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage driving the register file write port with a setup cycle
// followed by a one-cycle registered write strobe.
module writeback_stage import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rd_we,
  input  logic              ex_is_load,
  input  logic [2:0]        ex_funct3,
  input  logic [1:0]        ex_addr_lo,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [REG_AW-1:0] WR,
  output logic [XLEN-1:0]   WD,
  output logic              write,
  output logic              load_err,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);
  wb_state_t r_state, w_next;
  logic [REG_AW-1:0] r_rd, w_wr_d;
  logic [2:0] r_funct3;
  logic [1:0] r_addr_lo;
  logic r_commit;
  logic [XLEN-1:0] w_ld_data, w_wd_d;
  logic w_ld_illegal, w_accept, w_ld_accept, w_alu_commit, w_ld_done, w_ld_write;
  load_align #(.XLEN(XLEN)) u_align (
    .funct3(r_funct3),
    .addr_lo(r_addr_lo),
    .rdata(mem_rdata),
    .data(w_ld_data),
    .illegal(w_ld_illegal)
  );
  assign w_accept = r_state == IDLE && ex_valid;
  assign w_ld_accept = w_accept && ex_is_load;
  assign w_alu_commit = w_accept && !ex_is_load && ex_rd_we && ex_rd != '0;
  assign w_ld_done = r_state == WAIT_MEM && mem_rvalid;
  // Illegality is resolved at response time from the captured funct3/offset.
  assign w_ld_write = w_ld_done && r_commit && !w_ld_illegal;
  assign fwd_rd = WR;
  assign fwd_data = WD;
  always_ff @(posedge clk or negedge clear)
    if (!clear) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = (w_alu_commit || w_ld_write) ? SETUP :
             w_ld_accept ? WAIT_MEM :
             r_state == SETUP ? STROBE :
             (r_state == STROBE || w_ld_done) ? IDLE : r_state;
  end
  always_comb begin
    ex_ready = r_state == IDLE;
    w_wr_d = w_alu_commit ? ex_rd : r_rd;
    w_wd_d = w_alu_commit ? ex_result : w_ld_data;
  end
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      r_rd <= '0;
      r_funct3 <= '0;
      r_addr_lo <= '0;
      r_commit <= 1'b0;
    end else if (w_ld_accept) begin
      r_rd <= ex_rd;
      r_funct3 <= ex_funct3;
      r_addr_lo <= ex_addr_lo;
      r_commit <= ex_rd_we && ex_rd != '0;
    end
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      WR <= '0;
      WD <= '0;
      write <= 1'b0;
      load_err <= 1'b0;
      fwd_valid <= 1'b0;
    end else begin
      if (w_alu_commit || w_ld_write) begin
        WR <= w_wr_d;
        WD <= w_wd_d;
      end
      write <= r_state == SETUP;
      fwd_valid <= w_next == SETUP || w_next == STROBE;
      load_err <= w_ld_done && w_ld_illegal;
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors checked every cycle against a schedule-based model,
// plus hand-computed literal expectations.
module tb_writeback_stage;
  logic clk = 1'b0, clear = 1'b0;
  logic ex_valid = 1'b0, ex_rd_we = 1'b0, ex_is_load = 1'b0, mem_rvalid = 1'b0;
  logic [4:0] ex_rd = '0;
  logic [2:0] ex_funct3 = '0;
  logic [1:0] ex_addr_lo = '0;
  logic [31:0] ex_result = '0, mem_rdata = '0;
  logic ex_ready, write, load_err, fwd_valid;
  logic [4:0] WR, fwd_rd;
  logic [31:0] WD, fwd_data;
  int vectors = 0, miscompares = 0;

  writeback_stage dut (
    .clk(clk), .clear(clear), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .ex_result(ex_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .WR(WR), .WD(WD),
    .write(write), .load_err(load_err), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: natural alignment rule and shift/mask extraction.
  function automatic logic mdl_illegal(input logic [2:0] f3, input logic [1:0] o);
    int sz;
    sz = 1 << f3[1:0];
    return f3[1:0] == 2'b11 || (f3[2] && sz == 4) || (int'(o) % sz) != 0;
  endfunction

  function automatic logic [31:0] mdl_align(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] d);
    int bits;
    logic [31:0] v, mask;
    bits = 8 << f3[1:0];
    if (bits >= 32) return d;
    mask = (32'd1 << bits) - 32'd1;
    v = (d >> (8 * o)) & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  int cyc = 0, busy_until = -1, setup_at = -1, strobe_at = -1, err_at = -1;
  logic pend = 1'b0, p_commit = 1'b0;
  logic [4:0] p_rd = '0, m_wr = '0;
  logic [2:0] p_f3 = '0;
  logic [1:0] p_o = '0;
  logic [31:0] m_wd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      pend <= 1'b0;
      busy_until <= -1;
      setup_at <= -1;
      strobe_at <= -1;
      err_at <= -1;
      m_wr <= '0;
      m_wd <= '0;
    end else if (!pend && cyc > busy_until && ex_valid) begin
      if (ex_is_load) begin
        pend <= 1'b1;
        p_rd <= ex_rd;
        p_f3 <= ex_funct3;
        p_o <= ex_addr_lo;
        p_commit <= ex_rd_we && ex_rd != 0;
      end else if (ex_rd_we && ex_rd != 0) begin
        m_wr <= ex_rd;
        m_wd <= ex_result;
        setup_at <= cyc + 1;
        strobe_at <= cyc + 2;
        busy_until <= cyc + 2;
      end
    end else if (pend && mem_rvalid) begin
      pend <= 1'b0;
      if (mdl_illegal(p_f3, p_o)) err_at <= cyc + 1;
      else if (p_commit) begin
        m_wr <= p_rd;
        m_wd <= mdl_align(p_f3, p_o, mem_rdata);
        setup_at <= cyc + 1;
        strobe_at <= cyc + 2;
        busy_until <= cyc + 2;
      end
    end
  end

  always @(negedge clk) begin
    chk("ex_ready", 32'(ex_ready), 32'(!pend && cyc > busy_until));
    chk("write", 32'(write), 32'(cyc == strobe_at));
    chk("fwd_valid", 32'(fwd_valid), 32'(cyc == setup_at || cyc == strobe_at));
    chk("load_err", 32'(load_err), 32'(cyc == err_at));
    chk("WR", 32'(WR), 32'(m_wr));
    chk("WD", WD, m_wd);
    chk("fwd_rd", 32'(fwd_rd), 32'(m_wr));
    chk("fwd_data", fwd_data, m_wd);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic ld, input logic [4:0] rd, input logic we, input logic [2:0] f3,
                       input logic [1:0] o, input logic [31:0] res);
    int n = 0;
    while (!ex_ready && n < 50) begin step(1); n++; end
    chk("issue_ready", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_is_load = ld; ex_rd = rd; ex_rd_we = we;
    ex_funct3 = f3; ex_addr_lo = o; ex_result = res;
    step(1);
    ex_valid = 1'b0; ex_is_load = 1'b0;
  endtask

  task automatic respond(input int gap, input logic [31:0] d);
    step(gap);
    mem_rvalid = 1'b1; mem_rdata = d;
    step(1);
    mem_rvalid = 1'b0;
  endtask

  task automatic load_case(input logic [2:0] f3, input logic [1:0] o, input logic [4:0] rd,
                           input logic [31:0] d, input logic [31:0] exp_wd, input logic exp_err, input int gap);
    issue(1'b1, rd, 1'b1, f3, o, 32'h0);
    respond(gap, d);
    chk("ld_err_k1", 32'(load_err), 32'(exp_err));
    chk("ld_write_k1", 32'(write), 32'd0);
    if (!exp_err) chk("ld_wd_k1", WD, exp_wd);
    step(1);
    chk("ld_write_k2", 32'(write), 32'(!exp_err));
    chk("ld_err_k2", 32'(load_err), 32'd0);
    if (!exp_err) chk("ld_wr_k2", 32'(WR), 32'(rd));
    step(1);
    chk("ld_ready_after", 32'(ex_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_wr", 32'(WR), 32'd0);
    clear = 1'b1;
    step(1);
    // ALU write timing
    ex_valid = 1'b1; ex_rd = 5'd5; ex_rd_we = 1'b1; ex_is_load = 1'b0; ex_result = 32'hDEADBEEF;
    step(1);
    ex_valid = 1'b0;
    chk("alu_c1_wr", 32'(WR), 32'd5);
    chk("alu_c1_wd", WD, 32'hDEADBEEF);
    chk("alu_c1_write", 32'(write), 32'd0);
    chk("alu_c1_ready", 32'(ex_ready), 32'd0);
    step(1);
    chk("alu_c2_write", 32'(write), 32'd1);
    chk("alu_c2_ready", 32'(ex_ready), 32'd0);
    step(1);
    chk("alu_c3_write", 32'(write), 32'd0);
    chk("alu_c3_wr", 32'(WR), 32'd5);
    chk("alu_c3_wd", WD, 32'hDEADBEEF);
    chk("alu_c3_ready", 32'(ex_ready), 32'd1);
    // x0 suppression, then back-to-back accept
    ex_valid = 1'b1; ex_rd = 5'd0; ex_rd_we = 1'b1; ex_result = 32'h11111111;
    step(1);
    chk("x0_ready", 32'(ex_ready), 32'd1);
    chk("x0_fwd", 32'(fwd_valid), 32'd0);
    ex_rd = 5'd7; ex_result = 32'h12345678;
    step(1);
    ex_valid = 1'b0;
    chk("b2b_wr", 32'(WR), 32'd7);
    chk("b2b_wd", WD, 32'h12345678);
    step(2);
    issue(1'b0, 5'd3, 1'b0, 3'b000, 2'd0, 32'h55555555);
    chk("nowe_ready", 32'(ex_ready), 32'd1);
    chk("nowe_wd", WD, 32'h12345678);
    // Loads: legal alignments with varying response gaps
    load_case(3'b000, 2'd3, 5'd1, 32'h80112233, 32'hFFFFFF80, 1'b0, 0);
    load_case(3'b101, 2'd2, 5'd2, 32'h80112233, 32'h00008011, 1'b0, 2);
    load_case(3'b010, 2'd0, 5'd3, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1);
    load_case(3'b100, 2'd1, 5'd4, 32'h80112233, 32'h00000022, 1'b0, 3);
    load_case(3'b001, 2'd2, 5'd8, 32'h80112233, 32'hFFFF8011, 1'b0, 0);
    load_case(3'b001, 2'd0, 5'd9, 32'h80112233, 32'h00002233, 1'b0, 1);
    load_case(3'b000, 2'd0, 5'd10, 32'h80112233, 32'h00000033, 1'b0, 0);
    load_case(3'b100, 2'd3, 5'd11, 32'h80112233, 32'h00000080, 1'b0, 2);
    load_case(3'b001, 2'd0, 5'd12, 32'h0000F00D, 32'hFFFFF00D, 1'b0, 0);
    load_case(3'b101, 2'd0, 5'd13, 32'h0000F00D, 32'h0000F00D, 1'b0, 1);
    // Illegal / misaligned loads
    load_case(3'b001, 2'd1, 5'd14, 32'h80112233, 32'h0, 1'b1, 1);
    load_case(3'b011, 2'd0, 5'd15, 32'h80112233, 32'h0, 1'b1, 0);
    load_case(3'b010, 2'd2, 5'd16, 32'h80112233, 32'h0, 1'b1, 2);
    load_case(3'b110, 2'd0, 5'd17, 32'h80112233, 32'h0, 1'b1, 0);
    load_case(3'b101, 2'd3, 5'd18, 32'h80112233, 32'h0, 1'b1, 1);
    // Legal loads that must not write (x0 and rd_we=0)
    issue(1'b1, 5'd0, 1'b1, 3'b010, 2'd0, 32'h0);
    respond(1, 32'h99999999);
    step(1);
    chk("ldx0_write", 32'(write), 32'd0);
    chk("ldx0_ready", 32'(ex_ready), 32'd1);
    issue(1'b1, 5'd20, 1'b0, 3'b010, 2'd0, 32'h0);
    respond(0, 32'h77777777);
    step(1);
    chk("ldnowe_write", 32'(write), 32'd0);
    chk("ldnowe_wd", WD, 32'h0000F00D);
    // Stray response in IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'hABCDABCD;
    step(1);
    mem_rvalid = 1'b0;
    chk("stray_err", 32'(load_err), 32'd0);
    chk("stray_write", 32'(write), 32'd0);
    chk("stray_ready", 32'(ex_ready), 32'd1);
    step(1);
    // Reset during WAIT_MEM, late response ignored
    issue(1'b1, 5'd21, 1'b1, 3'b010, 2'd0, 32'h0);
    step(1);
    clear = 1'b0;
    #1;
    chk("rstw_ready", 32'(ex_ready), 32'd1);
    chk("rstw_wr", 32'(WR), 32'd0);
    chk("rstw_wd", WD, 32'd0);
    step(1);
    clear = 1'b1;
    respond(0, 32'h31313131);
    chk("rstw_late_err", 32'(load_err), 32'd0);
    step(1);
    chk("rstw_late_write", 32'(write), 32'd0);
    issue(1'b0, 5'd22, 1'b1, 3'b000, 2'd0, 32'h0BADF00D);
    chk("rstw_alu_wd", WD, 32'h0BADF00D);
    step(1);
    chk("rstw_alu_write", 32'(write), 32'd1);
    step(2);
    // Reset during SETUP
    issue(1'b0, 5'd23, 1'b1, 3'b000, 2'd0, 32'h01020304);
    clear = 1'b0;
    #1;
    chk("rsts_fwd", 32'(fwd_valid), 32'd0);
    chk("rsts_wd", WD, 32'd0);
    step(1);
    clear = 1'b1;
    step(2);
    // Reset during STROBE
    issue(1'b0, 5'd24, 1'b1, 3'b000, 2'd0, 32'h05060708);
    step(1);
    clear = 1'b0;
    #1;
    chk("rstb_write", 32'(write), 32'd0);
    chk("rstb_wr", 32'(WR), 32'd0);
    step(1);
    clear = 1'b1;
    // Reset while load_err is high
    issue(1'b1, 5'd25, 1'b1, 3'b111, 2'd0, 32'h0);
    respond(0, 32'h0);
    clear = 1'b0;
    #1;
    chk("rste_err", 32'(load_err), 32'd0);
    step(1);
    clear = 1'b1;
    issue(1'b0, 5'd26, 1'b1, 3'b000, 2'd0, 32'hFEEDFACE);
    step(1);
    chk("final_write", 32'(write), 32'd1);
    chk("final_wr", 32'(WR), 32'd26);
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
